// File: rtl/iopage_bus_ctl.sv
// I/O-page bus controller: decodes the top 8 KB of the 22-bit space, strobes the
// register slaves, and returns ack with read data or NXM after a decode timeout.
module iopage_bus_ctl #(
  parameter int NSLAVES = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [21:0]             bus_addr,
  input  logic                    bus_rd,
  input  logic                    bus_wr,
  input  logic                    bus_byte_op,
  input  logic [15:0]             bus_data_in,
  output logic [15:0]             bus_data_out,
  output logic                    bus_ack,
  output logic                    bus_nxm,
  output logic [12:0]             iopage_addr,
  output logic [15:0]             iopage_data,
  output logic                    iopage_rd,
  output logic                    iopage_wr,
  output logic                    iopage_byte_op,
  input  logic [NSLAVES-1:0]      slave_decode,
  input  logic [16*NSLAVES-1:0]   slave_data,
  output logic                    multi_hit
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ACCESS = 3'd1;
  localparam logic [2:0] ST_WAIT   = 3'd2;
  localparam logic [2:0] ST_DONE   = 3'd3;
  localparam logic [2:0] ST_ERR    = 3'd4;
  localparam logic [2:0] ST_REL    = 3'd5;

  logic [2:0]  state_reg;
  logic [7:0]  cnt_reg;
  logic        is_wr_reg;

  logic [15:0] slave_word [NSLAVES];
  logic [15:0] hit_word;
  logic [15:0] read_value;
  logic        hit_any;
  logic        hit_multi;
  logic        hit_found;
  logic        accept;

  genvar gi;
  generate
    for (gi = 0; gi < NSLAVES; gi++) begin : g_slave_word
      assign slave_word[gi] = slave_data[16*gi +: 16];
    end
  endgenerate

  // Lowest-index decoding slave wins the data path.
  always_comb begin
    hit_word  = 16'h0000;
    hit_found = 1'b0;
    for (int i = 0; i < NSLAVES; i++) begin
      if (!hit_found && slave_decode[i]) begin
        hit_word  = slave_word[i];
        hit_found = 1'b1;
      end
    end
  end

  assign hit_any    = |slave_decode;
  assign hit_multi  = |(slave_decode & (slave_decode - NSLAVES'(1)));
  assign read_value = iopage_byte_op
                    ? {8'h00, (iopage_addr[0] ? hit_word[15:8] : hit_word[7:0])}
                    : hit_word;
  assign accept     = (bus_addr[21:13] == 9'o777) && (bus_rd ^ bus_wr);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      cnt_reg        <= 8'd0;
      is_wr_reg      <= 1'b0;
      bus_data_out   <= 16'h0000;
      bus_ack        <= 1'b0;
      bus_nxm        <= 1'b0;
      iopage_addr    <= 13'h0000;
      iopage_data    <= 16'h0000;
      iopage_rd      <= 1'b0;
      iopage_wr      <= 1'b0;
      iopage_byte_op <= 1'b0;
      multi_hit      <= 1'b0;
    end else begin
      bus_ack   <= 1'b0;
      bus_nxm   <= 1'b0;
      iopage_wr <= 1'b0;

      if ((state_reg == ST_ACCESS || state_reg == ST_WAIT) && hit_multi)
        multi_hit <= 1'b1;

      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            iopage_addr    <= bus_addr[12:0];
            iopage_byte_op <= bus_byte_op;
            iopage_data    <= bus_byte_op ? {bus_data_in[7:0], bus_data_in[7:0]} : bus_data_in;
            iopage_rd      <= bus_rd;
            iopage_wr      <= bus_wr;
            is_wr_reg      <= bus_wr;
            state_reg      <= ST_ACCESS;
          end
        end
        ST_ACCESS, ST_WAIT: begin
          if (hit_any) begin
            bus_ack      <= 1'b1;
            bus_data_out <= is_wr_reg ? 16'h0000 : read_value;
            iopage_rd    <= 1'b0;
            // A late-decoding slave missed the original write strobe, so repeat it.
            iopage_wr    <= is_wr_reg && (state_reg == ST_WAIT);
            state_reg    <= ST_DONE;
          end else if (state_reg == ST_ACCESS) begin
            cnt_reg   <= 8'd1;
            state_reg <= ST_WAIT;
          end else if (cnt_reg == 8'(TIMEOUT)) begin
            bus_nxm      <= 1'b1;
            bus_data_out <= 16'h0000;
            iopage_rd    <= 1'b0;
            state_reg    <= ST_ERR;
          end else begin
            cnt_reg <= cnt_reg + 8'd1;
          end
        end
        ST_DONE, ST_ERR: state_reg <= ST_REL;
        ST_REL: begin
          if (!bus_rd && !bus_wr)
            state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iopage_bus_ctl.sv
// Randomized bench for iopage_bus_ctl: a transaction-level model predicts, per cycle,
// the strobes, ack/nxm timing, read data and the sticky multi-hit flag.
module tb_iopage_bus_ctl;
  localparam int NS = 8;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic [21:0]     bus_addr;
  logic            bus_rd, bus_wr, bus_byte_op;
  logic [15:0]     bus_data_in;
  logic [15:0]     bus_data_out;
  logic            bus_ack, bus_nxm;
  logic [12:0]     iopage_addr;
  logic [15:0]     iopage_data;
  logic            iopage_rd, iopage_wr, iopage_byte_op;
  logic [NS-1:0]   slave_decode;
  logic [16*NS-1:0] slave_data;
  logic            multi_hit;

  iopage_bus_ctl #(.NSLAVES(NS), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .bus_addr(bus_addr), .bus_rd(bus_rd), .bus_wr(bus_wr), .bus_byte_op(bus_byte_op),
    .bus_data_in(bus_data_in), .bus_data_out(bus_data_out),
    .bus_ack(bus_ack), .bus_nxm(bus_nxm),
    .iopage_addr(iopage_addr), .iopage_data(iopage_data),
    .iopage_rd(iopage_rd), .iopage_wr(iopage_wr), .iopage_byte_op(iopage_byte_op),
    .slave_decode(slave_decode), .slave_data(slave_data), .multi_hit(multi_hit)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] model_dout = 16'h0000;
  logic        model_mh   = 1'b0;
  logic [15:0] sw [NS];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // dly: cycles after the ACCESS cycle before the slaves decode (0 = decode in ACCESS).
  task automatic run_txn(input logic [21:0] a, input logic rd, input logic wr, input logic bop,
                         input logic [15:0] d, input logic [NS-1:0] mask, input int dly,
                         input int hold);
    logic        acc, hit;
    int          fin, win, last;
    logic [15:0] w, exp_word;
    logic [3:0]  exp_strb;
    acc = (a[21:13] == 9'h1FF) && (rd != wr);
    hit = acc && (mask != '0) && (dly <= TO);
    fin = hit ? dly + 1 : TO + 1;
    win = 0;
    for (int i = NS - 1; i >= 0; i--) if (mask[i]) win = i;
    w = sw[win];
    if (hit) begin
      exp_word = wr ? 16'h0000 : (bop ? {8'h00, (a[0] ? w[15:8] : w[7:0])} : w);
      if ($countones(mask) >= 2) model_mh = 1'b1;
    end else begin
      exp_word = acc ? 16'h0000 : model_dout;
    end

    @(negedge clk);
    bus_addr = a; bus_rd = rd; bus_wr = wr; bus_byte_op = bop; bus_data_in = d;
    slave_decode = '0;
    for (int i = 0; i < NS; i++) slave_data[16*i +: 16] = sw[i];
    last = acc ? fin + hold : hold + 2;
    for (int j = 0; j <= last; j++) begin
      @(negedge clk);
      if (!acc)             exp_strb = 4'b0000;
      else if (j == 0)      exp_strb = {1'b0, 1'b0, rd, wr};
      else if (j < fin)     exp_strb = {1'b0, 1'b0, rd, 1'b0};
      else if (j == fin)    exp_strb = {hit, !hit, 1'b0, hit && wr && (dly >= 1)};
      else                  exp_strb = 4'b0000;
      check($sformatf("strb j=%0d ack/nxm/rd/wr", j), {bus_ack, bus_nxm, iopage_rd, iopage_wr}, exp_strb);
      if (acc && j == 0) begin
        check("iopage_addr", iopage_addr, a[12:0]);
        check("iopage_data", iopage_data, bop ? {d[7:0], d[7:0]} : d);
        check("iopage_byte_op", iopage_byte_op, bop);
      end
      if (!acc || j >= fin) check("bus_data_out", bus_data_out, exp_word);
      slave_decode = (acc && j >= dly && j < fin) ? mask : '0;
    end
    model_dout = exp_word;
    bus_rd = 1'b0; bus_wr = 1'b0; slave_decode = '0;
    @(negedge clk);
    check("release ack/nxm/rd/wr", {bus_ack, bus_nxm, iopage_rd, iopage_wr}, 4'b0000);
    check("multi_hit", multi_hit, model_mh);
    $display("txn a=%o rd=%0d wr=%0d byte=%0d mask=%b dly=%0d -> %s data=%h", a, rd, wr, bop, mask,
             dly, !acc ? "ignored" : (hit ? "ack" : "nxm"), exp_word);
  endtask

  initial begin
    logic [21:0] a;
    logic        rd, wr;
    logic [NS-1:0] m;
    reset = 1'b1; bus_addr = '0; bus_rd = 0; bus_wr = 0; bus_byte_op = 0; bus_data_in = '0;
    slave_decode = '0; slave_data = '0;
    for (int i = 0; i < NS; i++) sw[i] = 16'($urandom);
    repeat (2) @(negedge clk);
    check("reset outputs", {bus_data_out, bus_ack, bus_nxm, iopage_addr, iopage_data,
                            iopage_rd, iopage_wr, iopage_byte_op, multi_hit}, 51'd0);
    reset = 1'b0;

    sw[2] = 16'o000340;
    run_txn(22'o17777776, 1, 0, 0, 16'h1234, 8'b0000_0100, 0, 0);
    run_txn(22'o17777777, 0, 1, 1, 16'hAB0F, 8'b0000_0001, 0, 0);
    run_txn(22'o17777700, 1, 0, 0, 16'h0000, 8'b0000_0000, 0, 0);
    sw[1] = 16'h1111; sw[3] = 16'h3333;
    run_txn(22'o17777710, 1, 0, 0, 16'h0000, 8'b0000_1010, 0, 0);
    run_txn(22'o17777712, 1, 0, 0, 16'h0000, 8'b0001_0000, 0, 5);
    run_txn(22'o17777720, 0, 1, 0, 16'hBEEF, 8'b0100_0000, 3, 1);
    run_txn(22'o17777721, 1, 0, 1, 16'h0000, 8'b1000_0000, TO, 0);
    run_txn(22'o17777722, 1, 0, 0, 16'h0000, 8'b1000_0000, TO + 1, 0);

    for (int t = 0; t < 60; t++) begin
      for (int i = 0; i < NS; i++) sw[i] = 16'($urandom);
      a  = ($urandom_range(0, 9) < 8) ? {9'h1FF, 13'($urandom)} : 22'($urandom);
      rd = 1'($urandom); wr = !rd;
      if ($urandom_range(0, 9) == 0) begin rd = 1; wr = 1; end
      m  = ($urandom_range(0, 4) == 0) ? '0 : NS'($urandom);
      run_txn(a, rd, wr, 1'($urandom), 16'($urandom), m, $urandom_range(0, TO + 4),
              $urandom_range(0, 3));
    end

    run_txn(22'o00001000, 1, 0, 0, 16'h0000, 8'b0000_0001, 0, 0);
    run_txn(22'o17777776, 1, 1, 0, 16'h5555, 8'b0000_0001, 0, 0);

    // Reset while a read is stuck in WAIT: everything clears, no late ack/nxm.
    @(negedge clk);
    bus_addr = 22'o17777740; bus_rd = 1; bus_wr = 0; slave_decode = '0;
    repeat (6) @(negedge clk);
    reset = 1'b1; bus_rd = 0;
    @(negedge clk);
    check("mid-wait reset outputs", {bus_data_out, bus_ack, bus_nxm, iopage_addr, iopage_data,
                                     iopage_rd, iopage_wr, iopage_byte_op, multi_hit}, 51'd0);
    reset = 1'b0; model_dout = 16'h0000; model_mh = 1'b0;
    for (int j = 0; j < TO + 4; j++) begin
      @(negedge clk);
      check("post-reset idle ack/nxm/rd/wr", {bus_ack, bus_nxm, iopage_rd, iopage_wr}, 4'b0000);
    end
    $display("txn reset during WAIT -> aborted");
    run_txn(22'o17777702, 1, 0, 0, 16'h0000, 8'b0000_0010, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/iopage_bus_ctl.md
Name: iopage_bus_ctl

Overview:
- Sits between the CPU/Unibus-side bus master and the I/O-page register blocks, such as the PSW, MMU, console and clock register files.
- Detects accesses to the top 8 KB of the 22-bit physical space, presents them to the slaves as iopage_addr/rd/wr/byte_op strobes, and collects each slave's decode/data_out pair.
- Returns either an acknowledge with read data, or a non-existent-memory (NXM) error after a timeout.

Parameters:
- NSLAVES, 8, number of I/O-page slave blocks on the decode/data vectors.
- TIMEOUT, 16, cycles spent in WAIT with no slave decode before NXM is signalled (valid range 1..255).

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- bus_addr  input  22  physical byte address from the master.
- bus_rd  input  1  read request; level, held until bus_ack or bus_nxm.
- bus_wr  input  1  write request; level, held until bus_ack or bus_nxm.
- bus_byte_op  input  1  byte access; lane selected by bus_addr[0].
- bus_data_in  input  16  write data; byte writes use [7:0].
- bus_data_out  output  16  registered read data.
- bus_ack  output  1  one-cycle completion pulse.
- bus_nxm  output  1  one-cycle timeout/error pulse.
- iopage_addr  output  13  registered bus_addr[12:0] to slaves.
- iopage_data  output  16  registered write data to slaves.
- iopage_rd  output  1  read strobe to slaves.
- iopage_wr  output  1  write strobe to slaves; single cycle.
- iopage_byte_op  output  1  registered bus_byte_op.
- slave_decode  input  NSLAVES  per-slave address-hit flags.
- slave_data  input  16*NSLAVES  per-slave read data; slave i occupies bits [16i+15:16i].
- multi_hit  output  1  sticky flag, set when more than one slave decodes; cleared only by reset.

Behaviour:
- Reset: clk is the clock; reset is synchronous and active-high. On reset all outputs go to 0 and the FSM goes to IDLE. Reset mid-transaction aborts it: no ack or nxm is issued, and strobes drop on the next edge.
- I/O-page hit: bus_addr[21:13] == 9'o777.
- IDLE:
  - Accept when the address is an I/O-page hit and exactly one of bus_rd/bus_wr is high.
  - Both rd and wr high, or a non-I/O-page address: ignored, stay in IDLE, no response.
  - On accept, latch the address, byte_op and data, then go to ACCESS.
- Byte write data: iopage_data = {bus_data_in[7:0], bus_data_in[7:0]}, so each slave picks the lane using iopage_addr[0]. Word writes pass bus_data_in through unchanged.
- ACCESS (1 cycle):
  - iopage_rd or iopage_wr is high.
  - Sample slave_decode. If any bit is set, go to DONE. Otherwise go to WAIT with the counter at 1.
- WAIT:
  - iopage_rd stays high for reads. iopage_wr is low (writes strobe once only).
  - slave_decode is re-sampled every cycle. A hit goes to DONE. For writes, a hit during WAIT issues one additional iopage_wr pulse in the DONE cycle.
  - The counter increments each cycle. When counter == TIMEOUT, go to ERR.
- Hit selection: the lowest-index set bit of slave_decode wins. If two or more bits are set in the sampled cycle, set multi_hit.
- Read data:
  - Word read: bus_data_out = the winning slave's word.
  - Byte read: bus_data_out = {8'b0, selected byte}, where bus_addr[0]=1 selects [15:8].
  - Write: bus_data_out = 0.
- DONE: bus_ack=1 for one cycle and bus_data_out is valid in that cycle. Strobes are low. Go to REL.
- ERR: bus_nxm=1 for one cycle, bus_data_out=0. Go to REL.
- REL: wait until bus_rd and bus_wr are both low, then go to IDLE. This prevents a held request being serviced twice.
- Latency:
  - Request to ack: 2 cycles for a hit in ACCESS (IDLE edge, then ACCESS edge).
  - Request to nxm: TIMEOUT+2 cycles.
- bus_data_out holds its value until the next DONE/ERR.
- Request changes while in ACCESS or WAIT are ignored; the latched values are used.

Test Plan:
- Word read 17777776, slave 2 decode=1 with data 16'o000340 -> iopage_rd high for 1 cycle, bus_ack 2 cycles after request, bus_data_out=000340.
- Byte write 17777777 with data 8'o017 -> iopage_wr pulse, iopage_byte_op=1, iopage_addr=13'o17777, iopage_data=16'h0F0F, ack.
- Read 17777700 with no slave decode, TIMEOUT=16 -> iopage_rd held, bus_nxm pulses at cycle 18, bus_data_out=0, no ack.
- Slaves 1 and 3 both decode, returning 16'h1111 and 16'h3333 -> data 1111, multi_hit=1 and stays set through later clean cycles until reset.
- Read held high after ack -> no second iopage_rd until the request drops for a cycle; then re-accept.
- Reset asserted in WAIT; read from address 00001000 (non-I/O-page); rd+wr together -> all outputs 0 the cycle after reset, FSM in IDLE, no ack/nxm for any of these.
